// File: rtl/bt_pkg.sv
// Shared definitions for the bluetooth packetizer: sync word, header field widths, FSM states.
// The header builder keeps the frame layout in one place.
package bt_pkg;

  localparam logic [15:0] SYNC_WORD = 16'hA55A;
  localparam int          SEQ_W     = 8;
  localparam int          LEN_W     = 8;
  localparam int          DATA_W    = 32;

  typedef enum logic [1:0] {
    FILL,
    HDR,
    PAYLOAD,
    TRAIL
  } state_t;

  function automatic logic [DATA_W-1:0] make_header(input logic [SEQ_W-1:0] seq,
                                                    input logic [LEN_W-1:0] len);
    return {SYNC_WORD, seq, len};
  endfunction

endpackage

// File: rtl/bt_pkt_buf.sv
// Payload store for one packet: written word by word while filling, read by pointer while sending.
module bt_pkt_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the array has no reset; every word is written before it is read, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bt_packetizer.sv
// Buffers upstream payload words into packets and emits header, payload and checksum trailer
// toward the bluetooth data interface.
module bt_packetizer
  import bt_pkg::*;
#(
  parameter int MAX_WORDS = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_last,
  output logic [31:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [SEQ_W-1:0] seq
);

  localparam int              AW       = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(MAX_WORDS - 1);

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  count, rd_ptr;
  logic [31:0]       checksum, buf_rdata;
  logic              s_fire, m_fire, close_pkt, last_payload;

  assign s_fire       = s_valid && s_ready;
  assign m_fire       = m_valid && m_ready;
  assign close_pkt    = s_fire && (s_last || count == LAST_IDX);
  assign last_payload = (rd_ptr == count - 1'b1);

  bt_pkt_buf #(.DEPTH(MAX_WORDS), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (s_fire),
    .waddr (count[AW-1:0]),
    .wdata (s_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FILL;
    else          state <= state_nxt;
  end

  // NOTE: every output gets a default before the case, so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_nxt = state;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    m_data    = '0;
    unique case (state)
      FILL: begin
        if (close_pkt) state_nxt = HDR;
      end
      HDR: begin
        m_valid = 1'b1;
        m_data  = make_header(seq, count);
        if (m_fire) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        m_valid = 1'b1;
        m_data  = buf_rdata;
        if (m_fire && last_payload) state_nxt = TRAIL;
      end
      TRAIL: begin
        m_valid = 1'b1;
        m_last  = 1'b1;
        m_data  = checksum;
        if (m_fire) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_ready  <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      checksum <= '0;
      seq      <= '0;
    end else begin
      // Registered ready drops the cycle after the closing accept and rises once back in FILL.
      s_ready <= (state_nxt == FILL);
      if (state == FILL && s_fire) begin
        count    <= count + 1'b1;
        checksum <= checksum + s_data;
      end
      if (state == PAYLOAD && m_fire) rd_ptr <= rd_ptr + 1'b1;
      if (state == TRAIL && m_fire) begin
        count    <= '0;
        rd_ptr   <= '0;
        checksum <= '0;
        seq      <= seq + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bt_packetizer.sv
// Self-checking bench for bt_packetizer: randomized streams against a queue-based packet model.
module tb_bt_packetizer;

  localparam int MAX_WORDS = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_last = 1'b0;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic [7:0]  seq;

  bt_packetizer #(.MAX_WORDS(MAX_WORDS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .seq     (seq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Stimulus and reference model state
  logic [31:0] in_w[$];
  bit          in_l[$];
  logic [32:0] exp_q[$];
  logic [7:0]  exp_seq[$];
  int          model_seq = 0;

  // Observed output stream
  logic [32:0] got_q[$];
  logic [7:0]  got_seq[$];
  int          got_cyc[$];
  int          stall_bad, ready_bad, last_acc_cyc;
  bit          coll_timeout, drv_timeout;

  task automatic start_case();
    in_w.delete(); in_l.delete(); exp_q.delete(); exp_seq.delete();
  endtask

  // Packet model: words gather until s_last or a full buffer, then header/payload/sum are emitted.
  task automatic model_build();
    logic [31:0] pend[$];
    logic [31:0] sum;
    foreach (in_w[i]) begin
      pend.push_back(in_w[i]);
      if (in_l[i] || pend.size() == MAX_WORDS) begin
        sum = '0;
        exp_q.push_back({1'b0, 16'hA55A, 8'(model_seq), 8'(pend.size())});
        exp_seq.push_back(8'(model_seq));
        foreach (pend[j]) begin
          exp_q.push_back({1'b0, pend[j]});
          exp_seq.push_back(8'(model_seq));
          sum += pend[j];
        end
        exp_q.push_back({1'b1, sum});
        exp_seq.push_back(8'(model_seq));
        model_seq = (model_seq + 1) % 256;
        pend.delete();
      end
    end
  endtask

  task automatic drive_all(input int idle_pct);
    int guard;
    drv_timeout = 1'b0;
    foreach (in_w[i]) begin
      while ($urandom_range(0, 99) < idle_pct) begin
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = $urandom;
        s_last  = 1'($urandom_range(0, 1));
      end
      guard = 0;
      do begin
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = in_w[i];
        s_last  = in_l[i];
        guard++;
      end while (!s_ready && guard < 20000);
      if (guard >= 20000) begin
        drv_timeout = 1'b1;
        break;
      end
      last_acc_cyc = cyc;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // mode 0: always ready, 1: toggle each cycle, 2: random
  task automatic collect(input int n, input int mode);
    logic [32:0] held = '0;
    bit          stalled = 1'b0;
    int          budget = 0;
    got_q.delete(); got_seq.delete(); got_cyc.delete();
    stall_bad = 0; ready_bad = 0; coll_timeout = 1'b0;
    while (got_q.size() < n) begin
      @(negedge clk);
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (stalled && (m_valid !== 1'b1 || {m_last, m_data} !== held)) stall_bad++;
      if (m_valid && s_ready) ready_bad++;
      stalled = 1'b0;
      if (m_valid) begin
        if (m_ready) begin
          got_q.push_back({m_last, m_data});
          got_seq.push_back(seq);
          got_cyc.push_back(cyc);
        end else begin
          stalled = 1'b1;
          held    = {m_last, m_data};
        end
      end
      budget++;
      if (budget > 20000) begin
        coll_timeout = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 m_ready = 1'b0;
  endtask

  task automatic run(input int mode, input int idle_pct);
    model_build();
    fork
      drive_all(idle_pct);
      collect(exp_q.size(), mode);
    join
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n   = 1'b1;
    model_seq = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({m_valid, m_last, s_ready} !== 3'b000 || m_data !== 32'h0 || seq !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_state: got valid=%b last=%b ready=%b data=%h seq=%h, want all zero",
               m_valid, m_last, s_ready, m_data, seq);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b, want 1", s_ready);
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_ready: got %b, want 0", s_ready);
    end
    @(negedge clk);
    reset_n   = 1'b1;
    model_seq = 0;
  endtask

  task automatic test_basic();
    start_case();
    in_w = '{32'h1, 32'h2, 32'h3};
    in_l = '{1'b0, 1'b0, 1'b1};
    run(0, 0);
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i] || got_seq[i] !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL basic word %0d: got %h seq %h, want %h seq %h", i,
                 (i < got_q.size()) ? got_q[i] : 33'h0, (i < got_q.size()) ? got_seq[i] : 8'h0,
                 exp_q[i], exp_seq[i]);
      end
    end
    vectors++;
    if (coll_timeout || drv_timeout || got_q.size() != 5 || got_q[0][31:0] !== 32'hA55A0003) begin
      miscompares++;
      $display("FAIL basic_header: got %0d words first %h, want 5 words first a55a0003", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 33'h0);
    end else begin
      vectors++;
      if (got_cyc[0] != last_acc_cyc + 1 || got_cyc[4] - got_cyc[0] != 4) begin
        miscompares++;
        $display("FAIL basic_timing: got hdr at +%0d span %0d, want +1 span 4",
                 got_cyc[0] - last_acc_cyc, got_cyc[4] - got_cyc[0]);
      end
    end
    vectors++;
    if (seq !== 8'(model_seq) || ready_bad != 0) begin
      miscompares++;
      $display("FAIL basic_seq: got seq %h ready_bad %0d, want seq %h ready_bad 0", seq, ready_bad, 8'(model_seq));
    end
  endtask

  task automatic test_backpressure();
    start_case();
    in_w = '{32'h1, 32'h2, 32'h3};
    in_l = '{1'b0, 1'b0, 1'b1};
    run(1, 0);
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i] || got_seq[i] !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL backpressure word %0d: got %h, want %h", i,
                 (i < got_q.size()) ? got_q[i] : 33'h0, exp_q[i]);
      end
    end
    vectors++;
    if (stall_bad != 0 || coll_timeout || drv_timeout) begin
      miscompares++;
      $display("FAIL backpressure_stable: got %0d unstable stalls timeout=%b, want 0", stall_bad, coll_timeout | drv_timeout);
    end
  endtask

  task automatic test_split();
    start_case();
    for (int i = 0; i < 20; i++) begin
      in_w.push_back(32'(i));
      in_l.push_back(i == 19);
    end
    // Exactly MAX_WORDS words with s_last on the final one: one packet, no empty follower.
    for (int i = 0; i < MAX_WORDS; i++) begin
      in_w.push_back($urandom);
      in_l.push_back(i == MAX_WORDS - 1);
    end
    run(0, 10);
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i] || got_seq[i] !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL split word %0d: got %h seq %h, want %h seq %h", i,
                 (i < got_q.size()) ? got_q[i] : 33'h0, (i < got_q.size()) ? got_seq[i] : 8'h0,
                 exp_q[i], exp_seq[i]);
      end
    end
    vectors++;
    if (got_q.size() < 24 || got_q[17] !== {1'b1, 32'h78} || got_q[23] !== {1'b1, 32'h46}) begin
      miscompares++;
      $display("FAIL split_sums: got %0d words, want trailers 78 and 46", got_q.size());
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (m_valid !== 1'b0 || coll_timeout || drv_timeout) begin
      miscompares++;
      $display("FAIL split_no_empty: got m_valid %b timeout %b, want 0", m_valid, coll_timeout | drv_timeout);
    end
  endtask

  task automatic test_wrap_sum();
    start_case();
    in_w = '{32'hFFFF_FFFF, 32'h0000_0002};
    in_l = '{1'b0, 1'b1};
    run(0, 0);
    vectors++;
    if (got_q.size() != 4 || got_q[3] !== {1'b1, 32'h0000_0001} || got_q[0] !== exp_q[0]) begin
      miscompares++;
      $display("FAIL wrap_sum: got %0d words trailer %h, want 4 words trailer 100000001", got_q.size(),
               (got_q.size() > 3) ? got_q[3] : 33'h0);
    end
  endtask

  task automatic test_random();
    start_case();
    for (int i = 0; i < 60; i++) begin
      in_w.push_back($urandom);
      in_l.push_back((i == 59) || ($urandom_range(0, 99) < 12));
    end
    run(2, 30);
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i] || got_seq[i] !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL random word %0d: got %h seq %h, want %h seq %h", i,
                 (i < got_q.size()) ? got_q[i] : 33'h0, (i < got_q.size()) ? got_seq[i] : 8'h0,
                 exp_q[i], exp_seq[i]);
      end
    end
    vectors++;
    if (stall_bad != 0 || ready_bad != 0 || coll_timeout || drv_timeout) begin
      miscompares++;
      $display("FAIL random_flow: got stall_bad %0d ready_bad %0d timeout %b, want 0 0 0",
               stall_bad, ready_bad, coll_timeout | drv_timeout);
    end
  endtask

  task automatic test_reset_midpacket();
    start_case();
    for (int i = 0; i < 5; i++) begin
      in_w.push_back($urandom);
      in_l.push_back(1'b0);
    end
    m_ready = 1'b1;
    drive_all(0);
    vectors++;
    if (m_valid !== 1'b0 || drv_timeout) begin
      miscompares++;
      $display("FAIL midpkt_idle: got m_valid %b, want 0", m_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (m_valid !== 1'b0 || seq !== 8'h0 || s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midpkt_reset: got valid %b seq %h ready %b, want 0 00 0", m_valid, seq, s_ready);
    end
    @(negedge clk);
    reset_n   = 1'b1;
    m_ready   = 1'b0;
    model_seq = 0;
    start_case();
    in_w = '{32'h0000_0010, 32'h0000_0020};
    in_l = '{1'b0, 1'b1};
    run(0, 0);
    vectors++;
    if (got_q.size() != 4 || got_q[0] !== {1'b0, 32'hA55A0002} || got_q[3] !== {1'b1, 32'h30}) begin
      miscompares++;
      $display("FAIL midpkt_next: got %0d words header %h, want 4 words header a55a0002 trailer 30",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 33'h0);
    end
  endtask

  task automatic test_seq_wrap();
    do_reset();
    start_case();
    for (int i = 0; i < 257; i++) begin
      in_w.push_back($urandom);
      in_l.push_back(1'b1);
    end
    run(0, 0);
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i] || got_seq[i] !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL seq_wrap word %0d: got %h seq %h, want %h seq %h", i,
                 (i < got_q.size()) ? got_q[i] : 33'h0, (i < got_q.size()) ? got_seq[i] : 8'h0,
                 exp_q[i], exp_seq[i]);
      end
    end
    vectors++;
    if (got_q.size() != 771 || got_q[768][15:8] !== 8'h00 || got_q[765][15:8] !== 8'hFF || seq !== 8'h01) begin
      miscompares++;
      $display("FAIL seq_wrap_end: got %0d words seq %h, want 771 words seq 01", got_q.size(), seq);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_split();
    test_wrap_sum();
    test_random();
    test_reset_midpacket();
    test_seq_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
